i2s_tx_clkgen: RTL and testbench
================================

// Module: i2s_tx_clkgen
// PURPOSE
//  Parametrised audio clock generator and stereo serial transmitter for the drum-sound DAC path.
//  Derives MCLK, BCLK and LRCLK from the system clock with configurable ratios.
//  Accepts stereo samples over a valid/ready handshake and shifts them out MSB-first in I2S or
//  left-justified framing. Flags underrun when no sample is ready at a frame boundary.
// PARAMETERS
//  MCLK_HALF  2   clk cycles per MCLK half-period (>=1)
//  BCLK_HALF  8   clk cycles per BCLK half-period (>=2)
//  SAMPLE_W   16  bits per channel sample (1..SLOT_W)
//  SLOT_W     32  BCLK periods per channel slot (>=SAMPLE_W, <=64)
//  MODE       0   0 = I2S (LRCLK=0 left, MSB 1 BCLK after LRCLK edge); 1 = left-justified (LRCLK=1 left, MSB aligned)
// PORTS
//  clk        in   1         system clock, 50 MHz
//  rst        in   1         asynchronous reset, active-high
//  en         in   1         run enable; low = clocks parked, counters cleared
//  s_valid    in   1         sample pair offered
//  s_left     in   SAMPLE_W  left sample, two's complement
//  s_right    in   SAMPLE_W  right sample, two's complement
//  s_ready    out  1         holding register empty; pair accepted when s_valid & s_ready
//  mclk       out  1         master clock to DAC
//  bclk       out  1         bit clock
//  lrclk      out  1         word-select clock
//  sdata      out  1         serial data, changes on BCLK falling edge
//  frame_start out 1         1-clk pulse when a new frame is loaded into the shifter
//  underrun   out  1         1-clk pulse when a frame loads with holding register empty
// BEHAVIOUR
//  Reset: mclk=bclk=sdata=frame_start=underrun=0; lrclk=0 (MODE 0) / 1 (MODE 1); holding empty, so s_ready=1.
//  All outputs are registered except s_ready (= ~hold_full). en=0 gives the same output state as reset.
//  The holding register is not cleared by en=0.
//  MCLK: counter 0..MCLK_HALF-1; mclk toggles on wrap. Free-running, independent of BCLK phase.
//  BCLK: counter 0..BCLK_HALF-1; bclk toggles on wrap. A "fall" event is the clk cycle bclk goes 1->0.
//  Bit counter 0..SLOT_W-1 and channel flag (0=left) advance on each fall event.
//  lrclk is updated on the fall event where the bit counter wraps.
//  Frame load: on the fall event that enters left slot bit 0:
//   - Holding full: the shifter loads {left,right} and holding is emptied.
//   - Holding empty: the shifter loads zeros and underrun pulses.
//   - frame_start pulses in either case.
//  Bit timing: in MODE 0 slot bit 0 outputs the previous slot's LSB-padding (0).
//   - MODE 0: bits 1..SAMPLE_W carry MSB..LSB. MODE 1: bits 0..SAMPLE_W-1 carry MSB..LSB.
//   - Remaining slot bits output 0.
//  Handshake: accept when s_valid&s_ready; holding becomes full next cycle.
//  s_left/s_right need to be stable only in the accept cycle.
//  Accept in the same cycle as a frame load (holding empty): the load uses zeros (underrun).
//  The accepted pair stays in holding for the next frame.
//  Accept while holding full is impossible (s_ready=0); s_valid is then ignored.
//  en rising: first bclk rise after BCLK_HALF clks; first frame load at first fall event (left slot bit 0).
//  Reset mid-frame: immediate async return to reset state; the partial frame is discarded.
// STRUCTURE
//  Shared include audio_defs.vh: MODE_I2S=0, MODE_LJ=1 constants, default ratio localparams.
//  Sub-module clk_half_div (params HALF; ports clk,rst,en -> out,rise,fall) instantiated for MCLK and BCLK.
//  Top holds bit/channel counters, holding register, 2*SAMPLE_W shifter, pulse flags.
// TESTING (MCLK_HALF=2, BCLK_HALF=8, SAMPLE_W=16, SLOT_W=32 unless noted)
//  1. Reset, en=1 -> mclk period 4 clk, bclk period 16 clk, lrclk period 1024 clk, 50% duty each.
//  2. MODE 0: offer L=16'hA5F0, R=16'h0F0F before frame 1.
//     -> left slot bits1..16 = A5F0 MSB-first, bit0 and bits17..31 = 0; same for right with 0F0F; no underrun.
//  3. MODE 1: same data -> MSB on bit 0 of each slot; lrclk=1 during left slot.
//  4. No s_valid for 3 frames -> underrun pulses 3 times (one per frame_start), sdata all 0, s_ready stays 1.
//  5. Hold s_valid=1 continuously with incrementing data -> one accept per frame; consecutive frames carry consecutive values.
//  6. Assert rst mid right slot, release after 5 clks -> outputs at reset values immediately, s_ready=1.
//     First frame after release matches scenario 1 timing.
//  7. SAMPLE_W=24, SLOT_W=24, MODE 0 -> LSB spans into next slot's bit 0 position check: bits 1..23 carry MSB..bit1.
//     Bench expects truncation of LSB; document as a known limit of SLOT_W=SAMPLE_W in I2S mode.

Source files
------------

// File: rtl/i2s_tx_clkgen_pkg.sv
// Shared constants and helpers for the I2S transmit clock generator.
package i2s_tx_clkgen_pkg;

    localparam int MODE_I2S = 0;
    localparam int MODE_LJ  = 1;

    localparam int DEF_MCLK_HALF = 2;
    localparam int DEF_BCLK_HALF = 8;
    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_SLOT_W    = 32;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // Word-select level for a channel: I2S drives 0 for left, LJ drives 1 for left.
    function automatic logic lr_level(input int mode, input chan_e ch);
        return (mode == MODE_LJ) ? (ch == CH_LEFT) : (ch == CH_RIGHT);
    endfunction

endpackage

// File: rtl/i2s_tx_clkgen_if.sv
// Sample-pair valid/ready handshake into the transmitter.
interface i2s_tx_clkgen_if #(
    parameter int SAMPLE_W = 16
);
    logic                s_valid;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;
    logic                s_ready;

    modport master (output s_valid, s_left, s_right, input s_ready);
    modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_clkgen_clk_half_div.sv
// Half-period divider: out toggles every HALF clk cycles while enabled.
// rise/fall are strobes in the cycle whose edge makes out go 0->1 / 1->0.
module clk_half_div
    import i2s_tx_clkgen_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic out,
    output logic rise,
    output logic fall
);
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          wrap;

    assign wrap = en && (cnt_q == CW'(HALF - 1));
    assign rise = wrap & ~out_q;
    assign fall = wrap & out_q;
    assign out  = out_q;

    // Next count/level; disable parks the output low with the count cleared.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        out_d = out_q;
        if (!en) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            out_d = ~out_q;
        end
    end

    // Divider state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end
endmodule

// File: rtl/i2s_tx_clkgen.sv
// Audio clock generator and stereo serial transmitter (I2S or left-justified).
// If SLOT_W leaves no room for every sample bit (I2S with SLOT_W == SAMPLE_W),
// the trailing LSBs of each channel are dropped; the next slot starts clean.
module i2s_tx_clkgen
    import i2s_tx_clkgen_pkg::*;
#(
    parameter int MCLK_HALF = DEF_MCLK_HALF,
    parameter int BCLK_HALF = DEF_BCLK_HALF,
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int SLOT_W    = DEF_SLOT_W,
    parameter int MODE      = MODE_I2S
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    i2s_tx_clkgen_if.slave s,
    output logic           mclk,
    output logic           bclk,
    output logic           lrclk,
    output logic           sdata,
    output logic           frame_start,
    output logic           underrun
);
    localparam int BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int OFF   = (MODE == MODE_I2S) ? 1 : 0;        // slot bit carrying the MSB
    localparam int DROP  = (SAMPLE_W + OFF > SLOT_W) ? (SAMPLE_W + OFF - SLOT_W) : 0;
    localparam int FW    = 2 * SAMPLE_W;

    logic mclk_rise, mclk_fall, bclk_rise, bclk_fall;
    logic unused_div;

    clk_half_div #(.HALF(MCLK_HALF)) u_mclk (
        .clk(clk), .rst(rst), .en(en), .out(mclk), .rise(mclk_rise), .fall(mclk_fall)
    );
    clk_half_div #(.HALF(BCLK_HALF)) u_bclk (
        .clk(clk), .rst(rst), .en(en), .out(bclk), .rise(bclk_rise), .fall(bclk_fall)
    );
    assign unused_div = ^{mclk_rise, mclk_fall, bclk_rise};

    logic [BIT_W-1:0]    bit_q, bit_d;
    chan_e               ch_q, ch_d;
    logic                lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic                fs_q, fs_d, ur_q, ur_d;
    logic [FW-1:0]       sh_q, sh_d, base;
    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] hl_q, hl_d, hr_q, hr_d;
    logic                slot_wrap, load, accept;
    logic [31:0]         bitx;

    assign accept      = s.s_valid & ~full_q;
    assign s.s_ready   = ~full_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

    // Slot/channel sequencing, frame load, serialiser and holding register.
    always_comb begin
        bit_d     = bit_q;
        ch_d      = ch_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        sh_d      = sh_q;
        fs_d      = 1'b0;
        ur_d      = 1'b0;
        full_d    = full_q;
        hl_d      = hl_q;
        hr_d      = hr_q;
        base      = sh_q;
        load      = 1'b0;
        slot_wrap = (bit_q == BIT_W'(SLOT_W - 1));
        bitx      = '0;
        if (!en) begin
            // Park as "last bit of right slot" so the first fall loads a frame.
            bit_d   = BIT_W'(SLOT_W - 1);
            ch_d    = CH_RIGHT;
            lrclk_d = lr_level(MODE, CH_LEFT);
            sdata_d = 1'b0;
            sh_d    = '0;
        end else if (bclk_fall) begin
            if (slot_wrap) begin
                bit_d   = '0;
                ch_d    = (ch_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                lrclk_d = lr_level(MODE, ch_d);
            end else begin
                bit_d = bit_q + 1'b1;
            end
            if (slot_wrap && ch_q == CH_RIGHT) begin
                load = 1'b1;
                fs_d = 1'b1;
                ur_d = ~full_q;
                base = full_q ? {hl_q, hr_q} : '0;
            end else if (slot_wrap) begin
                // Skip left LSBs that did not fit so the right MSB is on top.
                base = sh_q << DROP;
            end
            bitx = 32'(bit_d);
            if (bitx >= 32'(OFF) && bitx < 32'(OFF + SAMPLE_W)) begin
                sdata_d = base[FW-1];
                sh_d    = base << 1;
            end else begin
                sdata_d = 1'b0;
                sh_d    = base;
            end
        end
        if (accept) begin
            full_d = 1'b1;
            hl_d   = s.s_left;
            hr_d   = s.s_right;
        end else if (load && full_q) begin
            full_d = 1'b0;
        end
    end

    // Transmitter state register; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q   <= BIT_W'(SLOT_W - 1);
            ch_q    <= CH_RIGHT;
            lrclk_q <= lr_level(MODE, CH_LEFT);
            sdata_q <= 1'b0;
            sh_q    <= '0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
            full_q  <= 1'b0;
            hl_q    <= '0;
            hr_q    <= '0;
        end else begin
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            sh_q    <= sh_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
            full_q  <= full_d;
            hl_q    <= hl_d;
            hr_q    <= hr_d;
        end
    end
endmodule

// File: tb/tb_i2s_tx_clkgen.sv
// Self-checking bench: three instances (I2S 16/32, LJ 16/32, I2S 24/24),
// a bit-capture monitor, and a slot-format model built from the framing rules.
module tb_i2s_tx_clkgen;
    import i2s_tx_clkgen_pkg::*;

    logic clk = 1'b0;
    logic rst, en;
    int   cyc = 0;
    int   cmps = 0, errs = 0;
    int   sel = 0, slot = 32;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_tx_clkgen_if #(.SAMPLE_W(16)) if0 ();
    i2s_tx_clkgen_if #(.SAMPLE_W(16)) if1 ();
    i2s_tx_clkgen_if #(.SAMPLE_W(24)) if7 ();

    wire [2:0] mclk_w, bclk_w, lr_w, sd_w, fs_w, ur_w, rdy_w;
    assign rdy_w = {if7.s_ready, if1.s_ready, if0.s_ready};

    i2s_tx_clkgen #(.MCLK_HALF(2), .BCLK_HALF(8), .SAMPLE_W(16), .SLOT_W(32), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .s(if0), .mclk(mclk_w[0]), .bclk(bclk_w[0]),
        .lrclk(lr_w[0]), .sdata(sd_w[0]), .frame_start(fs_w[0]), .underrun(ur_w[0]));
    i2s_tx_clkgen #(.MCLK_HALF(2), .BCLK_HALF(8), .SAMPLE_W(16), .SLOT_W(32), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .s(if1), .mclk(mclk_w[1]), .bclk(bclk_w[1]),
        .lrclk(lr_w[1]), .sdata(sd_w[1]), .frame_start(fs_w[1]), .underrun(ur_w[1]));
    i2s_tx_clkgen #(.MCLK_HALF(2), .BCLK_HALF(8), .SAMPLE_W(24), .SLOT_W(24), .MODE(0)) dut7 (
        .clk(clk), .rst(rst), .en(en), .s(if7), .mclk(mclk_w[2]), .bclk(bclk_w[2]),
        .lrclk(lr_w[2]), .sdata(sd_w[2]), .frame_start(fs_w[2]), .underrun(ur_w[2]));

    // Captured frames of the selected instance (bit b of a slot at index b).
    logic [63:0] q_l[$], q_r[$], q_ll[$], q_lr[$];
    bit          q_ur[$];
    bit          ready_low, mon_in;
    int          mon_idx, fs_cnt, ur_cnt;

    // Monitor: sample sdata/lrclk on each bclk rise after a frame_start.
    initial begin
        logic [63:0] cl, cr, ll, lr;
        bit infr, pb, cur_ur;
        int idx;
        infr = 0; pb = 0; idx = 0; cur_ur = 0;
        cl = '0; cr = '0; ll = '0; lr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                infr = 0; pb = 0; idx = 0;
            end else begin
                if (ur_w[sel]) ur_cnt++;
                if (fs_w[sel]) begin
                    fs_cnt++;
                    infr = 1; idx = 0; cur_ur = ur_w[sel];
                    cl = '0; cr = '0; ll = '0; lr = '0;
                end else if (infr && bclk_w[sel] && !pb) begin
                    if (idx < slot) begin
                        cl[idx] = sd_w[sel]; ll[idx] = lr_w[sel];
                    end else begin
                        cr[idx-slot] = sd_w[sel]; lr[idx-slot] = lr_w[sel];
                    end
                    idx++;
                    if (idx == 2 * slot) begin
                        q_l.push_back(cl); q_r.push_back(cr);
                        q_ll.push_back(ll); q_lr.push_back(lr);
                        q_ur.push_back(cur_ur);
                        infr = 0;
                    end
                end
                if (!rdy_w[sel]) ready_low = 1;
                pb = bclk_w[sel];
            end
            mon_idx = idx; mon_in = infr;
        end
    end

    // Model: expected slot bits for a sample under the framing rules.
    function automatic logic [63:0] exp_slot(input logic [23:0] smp, input int w, input int sl, input int mode);
        logic [63:0] r;
        int off;
        r = '0;
        off = (mode == 0) ? 1 : 0;
        for (int b = 0; b < sl; b++)
            if (b - off >= 0 && b - off < w) r[b] = smp[w-1-(b-off)];
        return r;
    endfunction

    task automatic drive(input int d, input bit v, input logic [23:0] l, input logic [23:0] r);
        case (d)
            0: begin if0.s_valid = v; if0.s_left = l[15:0]; if0.s_right = r[15:0]; end
            1: begin if1.s_valid = v; if1.s_left = l[15:0]; if1.s_right = r[15:0]; end
            default: begin if7.s_valid = v; if7.s_left = l; if7.s_right = r; end
        endcase
    endtask

    task automatic do_reset(input int d, input int sl);
        rst = 1; en = 0;
        for (int i = 0; i < 3; i++) drive(i, 0, '0, '0);
        sel = d; slot = sl;
        repeat (3) @(negedge clk);
        q_l.delete(); q_r.delete(); q_ll.delete(); q_lr.delete(); q_ur.delete();
        ready_low = 0; fs_cnt = 0; ur_cnt = 0;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic offer(input int d, input logic [23:0] l, input logic [23:0] r);
        bit ok = 0;
        drive(d, 1, l, r);
        for (int i = 0; i < 3000; i++) begin
            if (rdy_w[d]) begin ok = 1; @(negedge clk); break; end
            @(negedge clk);
        end
        drive(d, 0, '0, '0);
        cmps++;
        if (!ok) begin errs++; $display("FAIL offer_timeout: accepted=%0d required=1", ok); end
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 1200 * n + 200; i++) begin
            if (q_l.size() >= n) begin ok = 1; break; end
            @(negedge clk);
        end
        cmps++;
        if (!ok) begin errs++; $display("FAIL frame_timeout: frames=%0d required=%0d", q_l.size(), n); end
    endtask

    task automatic test_reset;
        logic [6:0] got, exp;
        rst = 1; en = 0;
        for (int i = 0; i < 3; i++) drive(i, 0, '0, '0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            got = {mclk_w[d], bclk_w[d], lr_w[d], sd_w[d], fs_w[d], ur_w[d], rdy_w[d]};
            exp = {2'b00, (d == 1) ? 1'b1 : 1'b0, 3'b000, 1'b1};
            cmps++;
            if (got !== exp) begin errs++; $display("FAIL reset_state[%0d]: got %b required %b", d, got, exp); end
        end
        rst = 0;
        repeat (20) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            got = {mclk_w[d], bclk_w[d], lr_w[d], sd_w[d], fs_w[d], ur_w[d], rdy_w[d]};
            exp = {2'b00, (d == 1) ? 1'b1 : 1'b0, 3'b000, 1'b1};
            cmps++;
            if (got !== exp) begin errs++; $display("FAIL en0_parked[%0d]: got %b required %b", d, got, exp); end
        end
    endtask

    task automatic test_timing;
        int mr[$], mf[$], br[$], bf[$], lrr[$], lrf[$];
        int c0, fs_t, v;
        bit pm, pb, pl;
        do_reset(0, 32);
        en = 1; c0 = cyc; fs_t = -1;
        pm = mclk_w[0]; pb = bclk_w[0]; pl = lr_w[0];
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            if (mclk_w[0] && !pm) mr.push_back(cyc);
            if (!mclk_w[0] && pm) mf.push_back(cyc);
            if (bclk_w[0] && !pb) br.push_back(cyc);
            if (!bclk_w[0] && pb) bf.push_back(cyc);
            if (lr_w[0] && !pl) lrr.push_back(cyc);
            if (!lr_w[0] && pl) lrf.push_back(cyc);
            if (fs_w[0] && fs_t < 0) fs_t = cyc;
            pm = mclk_w[0]; pb = bclk_w[0]; pl = lr_w[0];
        end
        v = (br.size() > 0) ? br[0] - c0 : -1;
        cmps++; if (v !== 8) begin errs++; $display("FAIL first_bclk_rise: got %0d required 8", v); end
        v = (fs_t >= 0) ? fs_t - c0 : -1;
        cmps++; if (v !== 16) begin errs++; $display("FAIL first_frame_start: got %0d required 16", v); end
        v = (mr.size() > 1) ? mr[1] - mr[0] : -1;
        cmps++; if (v !== 4) begin errs++; $display("FAIL mclk_period: got %0d required 4", v); end
        v = (mf.size() > 0 && mr.size() > 0) ? mf[0] - mr[0] : -1;
        cmps++; if (v !== 2) begin errs++; $display("FAIL mclk_high: got %0d required 2", v); end
        v = (br.size() > 1) ? br[1] - br[0] : -1;
        cmps++; if (v !== 16) begin errs++; $display("FAIL bclk_period: got %0d required 16", v); end
        v = (bf.size() > 0 && br.size() > 0) ? bf[0] - br[0] : -1;
        cmps++; if (v !== 8) begin errs++; $display("FAIL bclk_high: got %0d required 8", v); end
        v = (lrr.size() > 1) ? lrr[1] - lrr[0] : -1;
        cmps++; if (v !== 1024) begin errs++; $display("FAIL lrclk_period: got %0d required 1024", v); end
        v = (lrf.size() > 0 && lrr.size() > 0) ? lrf[0] - lrr[0] : -1;
        cmps++; if (v !== 512) begin errs++; $display("FAIL lrclk_high: got %0d required 512", v); end
    endtask

    task automatic test_format(input int d, input int w, input int sl, input int mode);
        logic [23:0] l, r;
        logic [63:0] lm;
        bit ok;
        lm = (64'd1 << sl) - 64'd1;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                l = (w == 24) ? 24'hA5F0C3 : 24'h00A5F0;
                r = (w == 24) ? 24'h0F0F3C : 24'h000F0F;
            end else begin
                l = 24'($urandom() & ((32'd1 << w) - 1));
                r = 24'($urandom() & ((32'd1 << w) - 1));
            end
            do_reset(d, sl);
            offer(d, l, r);
            en = 1;
            wait_frames(1, ok);
            if (ok) begin
                cmps++; if (q_ur[0] !== 1'b0) begin errs++; $display("FAIL fmt%0d_underrun: got %b required 0", d, q_ur[0]); end
                cmps++; if (q_l[0] !== exp_slot(l, w, sl, mode)) begin errs++;
                    $display("FAIL fmt%0d_left: got %h required %h", d, q_l[0], exp_slot(l, w, sl, mode)); end
                cmps++; if (q_r[0] !== exp_slot(r, w, sl, mode)) begin errs++;
                    $display("FAIL fmt%0d_right: got %h required %h", d, q_r[0], exp_slot(r, w, sl, mode)); end
                cmps++; if (q_ll[0] !== ((mode == 1) ? lm : 64'd0)) begin errs++;
                    $display("FAIL fmt%0d_lrclk_left: got %h", d, q_ll[0]); end
                cmps++; if (q_lr[0] !== ((mode == 1) ? 64'd0 : lm)) begin errs++;
                    $display("FAIL fmt%0d_lrclk_right: got %h", d, q_lr[0]); end
                cmps++; if (rdy_w[d] !== 1'b1) begin errs++; $display("FAIL fmt%0d_ready: got %b required 1", d, rdy_w[d]); end
            end
        end
    endtask

    task automatic test_underrun;
        bit ok;
        do_reset(0, 32);
        en = 1;
        wait_frames(3, ok);
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                cmps++; if (q_ur[k] !== 1'b1) begin errs++; $display("FAIL underrun_flag[%0d]: got %b required 1", k, q_ur[k]); end
                cmps++; if ({q_l[k], q_r[k]} !== 128'd0) begin errs++;
                    $display("FAIL underrun_zero[%0d]: got %h %h required 0", k, q_l[k], q_r[k]); end
            end
        end
        cmps++; if (ready_low !== 1'b0) begin errs++; $display("FAIL underrun_ready: low seen %b required 0", ready_low); end
        cmps++; if (ur_cnt !== fs_cnt) begin errs++; $display("FAIL underrun_count: got %0d required %0d", ur_cnt, fs_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] cur, accq[$];
        bit pend, ok;
        do_reset(0, 32);
        cur = 16'($urandom());
        pend = 0;
        drive(0, 1, {8'h0, cur}, {8'h0, ~cur});
        en = 1;
        ok = 0;
        for (int i = 0; i < 4600; i++) begin
            if (q_l.size() >= 4) begin ok = 1; break; end
            if (rdy_w[0]) begin accq.push_back(cur); pend = 1; end
            @(negedge clk);
            if (pend) begin cur = cur + 16'd1; drive(0, 1, {8'h0, cur}, {8'h0, ~cur}); pend = 0; end
        end
        drive(0, 0, '0, '0);
        cmps++; if (!ok) begin errs++; $display("FAIL b2b_timeout: frames=%0d required 4", q_l.size()); end
        cmps++; if (accq.size() !== 5) begin errs++; $display("FAIL b2b_accepts: got %0d required 5", accq.size()); end
        if (ok && accq.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                cmps++; if (q_ur[k] !== 1'b0) begin errs++; $display("FAIL b2b_underrun[%0d]: got 1 required 0", k); end
                cmps++; if (q_l[k] !== exp_slot({8'h0, accq[k]}, 16, 32, 0)) begin errs++;
                    $display("FAIL b2b_left[%0d]: got %h required %h", k, q_l[k], exp_slot({8'h0, accq[k]}, 16, 32, 0)); end
                cmps++; if (q_r[k] !== exp_slot({8'h0, ~accq[k]}, 16, 32, 0)) begin errs++;
                    $display("FAIL b2b_right[%0d]: got %h required %h", k, q_r[k], exp_slot({8'h0, ~accq[k]}, 16, 32, 0)); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [6:0] got;
        int c0, fs_t;
        bit ok;
        do_reset(0, 32);
        offer(0, 24'h00A5F0, 24'h000F0F);
        en = 1;
        ok = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (mon_in && mon_idx > slot + 3) begin ok = 1; break; end
        end
        cmps++; if (!ok) begin errs++; $display("FAIL mid_reach_right: reached %b required 1", ok); end
        rst = 1;
        #1;
        got = {mclk_w[0], bclk_w[0], lr_w[0], sd_w[0], fs_w[0], ur_w[0], rdy_w[0]};
        cmps++; if (got !== 7'b0000001) begin errs++; $display("FAIL mid_reset_state: got %b required 0000001", got); end
        repeat (5) @(negedge clk);
        q_l.delete(); q_r.delete(); q_ll.delete(); q_lr.delete(); q_ur.delete();
        rst = 0; c0 = cyc; fs_t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fs_w[0]) begin fs_t = cyc - c0; break; end
        end
        cmps++; if (fs_t !== 16) begin errs++; $display("FAIL mid_restart_fs: got %0d required 16", fs_t); end
        wait_frames(1, ok);
        if (ok) begin
            cmps++; if (q_ur[0] !== 1'b1) begin errs++; $display("FAIL mid_restart_underrun: got %b required 1", q_ur[0]); end
            cmps++; if ({q_l[0], q_r[0]} !== 128'd0) begin errs++; $display("FAIL mid_restart_data: got %h %h required 0", q_l[0], q_r[0]); end
        end
    endtask

    initial begin
        rst = 1; en = 0;
        for (int i = 0; i < 3; i++) drive(i, 0, '0, '0);
        test_reset;
        test_timing;
        test_format(0, 16, 32, 0);
        test_format(1, 16, 32, 1);
        test_underrun;
        test_back_to_back;
        test_reset_mid;
        test_format(2, 24, 24, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: sim time limit reached, compared %0d", cmps);
        $fatal(1, "watchdog");
    end
endmodule
